// File: rtl/xbar_slave_id_tracker_pkg.sv
// Shared sizing helpers for the slave-side ID tracker and its outstanding-transaction FIFO.
// The FIFO entry layout depends on module parameters, so it is declared as a struct inside the top.
package xbar_slave_id_tracker_pkg;

    localparam int unsigned DEF_ID_WIDTH  = 9;
    localparam int unsigned DEF_AUX_WIDTH = 8;

    // Pointer width for a power-of-two depth; a depth below 2 still needs one bit.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    function automatic int unsigned count_width(input int unsigned depth);
        return ptr_width(depth) + 1;
    endfunction

endpackage

// File: rtl/xbar_id_fifo.sv
// Register-file FIFO with combinational head read, occupancy count and async active-low reset.
// Storage is not reset; only pointers and count carry reset state.
module xbar_id_fifo
    import xbar_slave_id_tracker_pkg::*;
#(
    parameter int unsigned WIDTH = 17,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = ptr_width(DEPTH),
    localparam int unsigned CNT_W = count_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == FULL_CNT);
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign rdata   = mem[rd_ptr];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            // Power-of-two depth lets the pointers wrap by natural overflow.
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/xbar_slave_id_tracker.sv
// Re-attaches bridge ID/AUX to responses from an in-order, ID-less target by queuing them per
// granted request; bounds outstanding transactions and flags responses with no pending request.
module xbar_slave_id_tracker
    import xbar_slave_id_tracker_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned BE_WIDTH        = DATA_WIDTH / 8,
    parameter int unsigned ID_WIDTH        = DEF_ID_WIDTH,
    parameter int unsigned AUX_WIDTH       = DEF_AUX_WIDTH,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,

    input  logic                               data_req_i,
    input  logic [ADDR_WIDTH-1:0]              data_add_i,
    input  logic                               data_wen_i,
    input  logic [DATA_WIDTH-1:0]              data_wdata_i,
    input  logic [BE_WIDTH-1:0]                data_be_i,
    input  logic [ID_WIDTH-1:0]                data_ID_i,
    input  logic [AUX_WIDTH-1:0]               data_aux_i,
    output logic                               data_gnt_o,

    output logic                               data_r_valid_o,
    output logic [DATA_WIDTH-1:0]              data_r_rdata_o,
    output logic [ID_WIDTH-1:0]                data_r_ID_o,
    output logic                               data_r_opc_o,
    output logic [AUX_WIDTH-1:0]               data_r_aux_o,

    output logic                               per_req_o,
    output logic [ADDR_WIDTH-1:0]              per_add_o,
    output logic                               per_wen_o,
    output logic [DATA_WIDTH-1:0]              per_wdata_o,
    output logic [BE_WIDTH-1:0]                per_be_o,
    input  logic                               per_gnt_i,
    input  logic                               per_r_valid_i,
    input  logic [DATA_WIDTH-1:0]              per_r_rdata_i,
    input  logic                               per_r_opc_i,

    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_o,
    output logic                               orphan_err_o
);

    typedef struct packed {
        logic [ID_WIDTH-1:0]  id;
        logic [AUX_WIDTH-1:0] aux;
    } entry_t;

    entry_t push_entry;
    entry_t head_entry;
    logic   full;
    logic   empty;
    logic   push;
    logic   pop;
    logic   orphan;

    assign per_req_o   = data_req_i & ~full;
    assign data_gnt_o  = per_gnt_i & ~full;
    assign per_add_o   = data_add_i;
    assign per_wen_o   = data_wen_i;
    assign per_wdata_o = data_wdata_i;
    assign per_be_o    = data_be_i;

    // Full is judged on the registered count only: a same-cycle pop does not free a slot.
    assign push   = data_req_i & per_gnt_i & ~full;
    // A response while empty is an orphan even if a push lands this cycle; the head is not yet written.
    assign pop    = per_r_valid_i & ~empty;
    assign orphan = per_r_valid_i & empty;

    assign push_entry.id  = data_ID_i;
    assign push_entry.aux = data_aux_i;

    xbar_id_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (push_entry),
        .rdata (head_entry),
        .full  (full),
        .empty (empty),
        .count (outstanding_o)
    );

    // Response stage: one register between the target response and the bridge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r_valid_o <= 1'b0;
            data_r_rdata_o <= '0;
            data_r_ID_o    <= '0;
            data_r_opc_o   <= 1'b0;
            data_r_aux_o   <= '0;
        end else begin
            data_r_valid_o <= pop;
            if (pop) begin
                data_r_rdata_o <= per_r_rdata_i;
                data_r_opc_o   <= per_r_opc_i;
                data_r_ID_o    <= head_entry.id;
                data_r_aux_o   <= head_entry.aux;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) orphan_err_o <= 1'b0;
        else if (orphan) orphan_err_o <= 1'b1;
    end

endmodule

// File: tb/tb_xbar_slave_id_tracker.sv
// Scoreboard bench for xbar_slave_id_tracker: queued request IDs become expected responses.
module tb_xbar_slave_id_tracker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        data_req_i;
    logic [31:0] data_add_i;
    logic        data_wen_i;
    logic [31:0] data_wdata_i;
    logic [3:0]  data_be_i;
    logic [8:0]  data_ID_i;
    logic [7:0]  data_aux_i;
    logic        data_gnt_o;
    logic        data_r_valid_o;
    logic [31:0] data_r_rdata_o;
    logic [8:0]  data_r_ID_o;
    logic        data_r_opc_o;
    logic [7:0]  data_r_aux_o;
    logic        per_req_o;
    logic [31:0] per_add_o;
    logic        per_wen_o;
    logic [31:0] per_wdata_o;
    logic [3:0]  per_be_o;
    logic        per_gnt_i;
    logic        per_r_valid_i;
    logic [31:0] per_r_rdata_i;
    logic        per_r_opc_i;
    logic [2:0]  outstanding_o;
    logic        orphan_err_o;

    xbar_slave_id_tracker dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .data_req_i     (data_req_i),
        .data_add_i     (data_add_i),
        .data_wen_i     (data_wen_i),
        .data_wdata_i   (data_wdata_i),
        .data_be_i      (data_be_i),
        .data_ID_i      (data_ID_i),
        .data_aux_i     (data_aux_i),
        .data_gnt_o     (data_gnt_o),
        .data_r_valid_o (data_r_valid_o),
        .data_r_rdata_o (data_r_rdata_o),
        .data_r_ID_o    (data_r_ID_o),
        .data_r_opc_o   (data_r_opc_o),
        .data_r_aux_o   (data_r_aux_o),
        .per_req_o      (per_req_o),
        .per_add_o      (per_add_o),
        .per_wen_o      (per_wen_o),
        .per_wdata_o    (per_wdata_o),
        .per_be_o       (per_be_o),
        .per_gnt_i      (per_gnt_i),
        .per_r_valid_i  (per_r_valid_i),
        .per_r_rdata_i  (per_r_rdata_i),
        .per_r_opc_i    (per_r_opc_i),
        .outstanding_o  (outstanding_o),
        .orphan_err_o   (orphan_err_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [8:0] id;
        logic [7:0] aux;
    } req_t;

    typedef struct packed {
        logic [8:0]  id;
        logic [7:0]  aux;
        logic [31:0] rdata;
        logic        opc;
    } rsp_t;

    req_t req_q[$];
    rsp_t exp_q[$];
    int   mcnt;
    logic morphan;
    logic obs_gnt, obs_req, exp_gnt_c, exp_req_c;
    int   total = 0;
    int   bad = 0;

    task automatic model_clear();
        mcnt    = 0;
        morphan = 1'b0;
        req_q.delete();
        exp_q.delete();
    endtask

    // Drive one cycle of stimulus, update the reference model, then step to 1ns past the edge.
    task automatic drive_cycle(input logic r, input logic g, input logic rv, input logic [8:0] i,
                               input logic [7:0] a, input logic [31:0] rd, input logic op);
        logic full, push, pop;
        req_t h;
        rsp_t e;
        data_req_i    = r;
        data_add_i    = $urandom;
        data_wen_i    = 1'($urandom_range(0, 1));
        data_wdata_i  = $urandom;
        data_be_i     = 4'($urandom_range(0, 15));
        data_ID_i     = i;
        data_aux_i    = a;
        per_gnt_i     = g;
        per_r_valid_i = rv;
        per_r_rdata_i = rd;
        per_r_opc_i   = op;
        #1;
        obs_gnt   = data_gnt_o;
        obs_req   = per_req_o;
        full      = (mcnt == 4);
        exp_gnt_c = g & ~full;
        exp_req_c = r & ~full;
        push      = r & g & ~full;
        pop       = rv & (mcnt != 0);
        if (pop) begin
            h       = req_q.pop_front();
            e.id    = h.id;
            e.aux   = h.aux;
            e.rdata = rd;
            e.opc   = op;
            exp_q.push_back(e);
        end
        if (rv && mcnt == 0) morphan = 1'b1;
        if (push) begin
            h.id  = i;
            h.aux = a;
            req_q.push_back(h);
        end
        mcnt = mcnt + (push ? 1 : 0) - (pop ? 1 : 0);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        drive_cycle(1'b0, 1'b0, 1'b0, 9'h0, 8'h0, 32'h0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        model_clear();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        data_req_i = 0; data_add_i = 0; data_wen_i = 0; data_wdata_i = 0; data_be_i = 0;
        data_ID_i = 0; data_aux_i = 0; per_gnt_i = 0; per_r_valid_i = 0; per_r_rdata_i = 0;
        per_r_opc_i = 0;
        model_clear();
        #12;
        total++;
        if ({data_r_valid_o, data_r_rdata_o, data_r_ID_o, data_r_opc_o, data_r_aux_o} !== '0) begin
            bad++;
            $display("FAIL reset_rsp: got v=%b rd=%h id=%h opc=%b aux=%h want all 0",
                     data_r_valid_o, data_r_rdata_o, data_r_ID_o, data_r_opc_o, data_r_aux_o);
        end
        total++;
        if (outstanding_o !== 3'd0 || orphan_err_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_status: got cnt=%0d orphan=%b want 0 0", outstanding_o, orphan_err_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_load();
        rsp_t e;
        do_reset();
        drive_cycle(1'b1, 1'b1, 1'b0, 9'h004, 8'h5A, 32'h0, 1'b0);
        total++;
        if (obs_gnt !== exp_gnt_c || obs_req !== exp_req_c) begin
            bad++;
            $display("FAIL single_grant: got gnt=%b req=%b want %b %b", obs_gnt, obs_req, exp_gnt_c, exp_req_c);
        end
        total++;
        if (per_add_o !== data_add_i || per_wdata_o !== data_wdata_i || per_be_o !== data_be_i || per_wen_o !== data_wen_i) begin
            bad++;
            $display("FAIL passthru: got add=%h wd=%h be=%h wen=%b want %h %h %h %b", per_add_o, per_wdata_o,
                     per_be_o, per_wen_o, data_add_i, data_wdata_i, data_be_i, data_wen_i);
        end
        total++;
        if (outstanding_o !== 3'(mcnt)) begin
            bad++;
            $display("FAIL single_cnt1: got %0d want %0d", outstanding_o, mcnt);
        end
        idle_cycle();
        total++;
        if (data_r_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL single_early_valid: got %b want 0", data_r_valid_o);
        end
        drive_cycle(1'b0, 1'b0, 1'b1, 9'h0, 8'h0, 32'hDEADBEEF, 1'b0);
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL single_rsp: got no expected entry want 1");
        end else begin
            e = exp_q.pop_front();
            if (data_r_valid_o !== 1'b1 || data_r_rdata_o !== e.rdata || data_r_ID_o !== e.id ||
                data_r_aux_o !== e.aux || data_r_opc_o !== e.opc || data_r_rdata_o !== 32'hDEADBEEF) begin
                bad++;
                $display("FAIL single_rsp: got v=%b rd=%h id=%h aux=%h opc=%b want 1 %h %h %h %b",
                         data_r_valid_o, data_r_rdata_o, data_r_ID_o, data_r_aux_o, data_r_opc_o,
                         e.rdata, e.id, e.aux, e.opc);
            end
        end
        total++;
        if (outstanding_o !== 3'd0) begin
            bad++;
            $display("FAIL single_cnt0: got %0d want 0", outstanding_o);
        end
    endtask

    task automatic test_fill_full();
        rsp_t e;
        logic [8:0] ids [4];
        ids[0] = 9'h001; ids[1] = 9'h002; ids[2] = 9'h004; ids[3] = 9'h008;
        do_reset();
        for (int k = 0; k < 4; k++) drive_cycle(1'b1, 1'b1, 1'b0, ids[k], 8'(8'h10 + k), 32'h0, 1'b0);
        total++;
        if (outstanding_o !== 3'd4) begin
            bad++;
            $display("FAIL full_cnt: got %0d want 4", outstanding_o);
        end
        drive_cycle(1'b1, 1'b1, 1'b0, 9'h010, 8'h77, 32'h0, 1'b0);
        total++;
        if (obs_gnt !== 1'b0 || obs_req !== 1'b0 || outstanding_o !== 3'd4) begin
            bad++;
            $display("FAIL full_block: got gnt=%b req=%b cnt=%0d want 0 0 4", obs_gnt, obs_req, outstanding_o);
        end
        // Full with a simultaneous pop: the request is still refused.
        drive_cycle(1'b1, 1'b1, 1'b1, 9'h020, 8'h88, 32'hA0A0_0000, 1'b0);
        total++;
        if (obs_gnt !== exp_gnt_c || obs_req !== exp_req_c || outstanding_o !== 3'(mcnt)) begin
            bad++;
            $display("FAIL full_pop_block: got gnt=%b req=%b cnt=%0d want %b %b %0d", obs_gnt, obs_req,
                     outstanding_o, exp_gnt_c, exp_req_c, mcnt);
        end
        for (int k = 0; k < 4; k++) begin
            if (k > 0) drive_cycle(1'b0, 1'b0, 1'b1, 9'h0, 8'h0, 32'hA0A0_0000 + 32'(k), 1'b0);
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL full_rsp%0d: got no expected entry want 1", k);
            end else begin
                e = exp_q.pop_front();
                if (data_r_valid_o !== 1'b1 || data_r_ID_o !== e.id || data_r_ID_o !== ids[k] ||
                    data_r_aux_o !== e.aux || data_r_rdata_o !== e.rdata) begin
                    bad++;
                    $display("FAIL full_rsp%0d: got v=%b id=%h aux=%h rd=%h want 1 %h %h %h", k, data_r_valid_o,
                             data_r_ID_o, data_r_aux_o, data_r_rdata_o, e.id, e.aux, e.rdata);
                end
            end
        end
    endtask

    task automatic test_push_pop();
        rsp_t e;
        do_reset();
        drive_cycle(1'b1, 1'b1, 1'b0, 9'h010, 8'hC1, 32'h0, 1'b0);
        drive_cycle(1'b1, 1'b1, 1'b0, 9'h020, 8'hC2, 32'h0, 1'b0);
        drive_cycle(1'b1, 1'b1, 1'b1, 9'h040, 8'hC3, 32'h1234_5678, 1'b1);
        for (int k = 0; k < 3; k++) begin
            if (k == 0) begin
                total++;
                if (outstanding_o !== 3'd2 || obs_gnt !== 1'b1) begin
                    bad++;
                    $display("FAIL pp_cnt: got cnt=%0d gnt=%b want 2 1", outstanding_o, obs_gnt);
                end
            end else begin
                drive_cycle(1'b0, 1'b0, 1'b1, 9'h0, 8'h0, 32'h0BAD_0000 + 32'(k), 1'b0);
            end
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL pp_rsp%0d: got no expected entry want 1", k);
            end else begin
                e = exp_q.pop_front();
                if (data_r_valid_o !== 1'b1 || data_r_ID_o !== e.id || data_r_aux_o !== e.aux ||
                    data_r_rdata_o !== e.rdata || data_r_opc_o !== e.opc) begin
                    bad++;
                    $display("FAIL pp_rsp%0d: got v=%b id=%h aux=%h rd=%h opc=%b want 1 %h %h %h %b", k,
                             data_r_valid_o, data_r_ID_o, data_r_aux_o, data_r_rdata_o, data_r_opc_o,
                             e.id, e.aux, e.rdata, e.opc);
                end
            end
        end
    endtask

    task automatic test_wrap();
        rsp_t e;
        logic [8:0] id;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            id = 9'h001 << (i % 9);
            drive_cycle(1'b1, 1'b1, 1'b0, id, 8'(8'h30 + i), 32'h0, 1'b0);
            drive_cycle(1'b0, 1'b0, 1'b1, 9'h0, 8'h0, $urandom, 1'($urandom_range(0, 1)));
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL wrap_rsp%0d: got no expected entry want 1", i);
            end else begin
                e = exp_q.pop_front();
                if (data_r_valid_o !== 1'b1 || data_r_ID_o !== e.id || data_r_ID_o !== id ||
                    data_r_aux_o !== e.aux || data_r_rdata_o !== e.rdata || data_r_opc_o !== e.opc) begin
                    bad++;
                    $display("FAIL wrap_rsp%0d: got v=%b id=%h aux=%h rd=%h opc=%b want 1 %h %h %h %b", i,
                             data_r_valid_o, data_r_ID_o, data_r_aux_o, data_r_rdata_o, data_r_opc_o,
                             e.id, e.aux, e.rdata, e.opc);
                end
            end
        end
    endtask

    task automatic test_orphan();
        rsp_t e;
        do_reset();
        drive_cycle(1'b0, 1'b0, 1'b1, 9'h0, 8'h0, 32'h5555_AAAA, 1'b0);
        total++;
        if (data_r_valid_o !== 1'b0 || orphan_err_o !== morphan || outstanding_o !== 3'd0) begin
            bad++;
            $display("FAIL orphan_empty: got v=%b orphan=%b cnt=%0d want 0 %b 0", data_r_valid_o,
                     orphan_err_o, outstanding_o, morphan);
        end
        // Response coinciding with a push into an empty FIFO is still an orphan.
        drive_cycle(1'b1, 1'b1, 1'b1, 9'h080, 8'hE7, 32'h6666_0000, 1'b0);
        total++;
        if (data_r_valid_o !== 1'b0 || outstanding_o !== 3'(mcnt) || orphan_err_o !== 1'b1) begin
            bad++;
            $display("FAIL orphan_push: got v=%b cnt=%0d orphan=%b want 0 %0d 1", data_r_valid_o,
                     outstanding_o, orphan_err_o, mcnt);
        end
        drive_cycle(1'b0, 1'b0, 1'b1, 9'h0, 8'h0, 32'h7777_0001, 1'b0);
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL orphan_follow: got no expected entry want 1");
        end else begin
            e = exp_q.pop_front();
            if (data_r_valid_o !== 1'b1 || data_r_ID_o !== e.id || data_r_aux_o !== e.aux ||
                data_r_rdata_o !== e.rdata || orphan_err_o !== 1'b1) begin
                bad++;
                $display("FAIL orphan_follow: got v=%b id=%h aux=%h rd=%h orphan=%b want 1 %h %h %h 1",
                         data_r_valid_o, data_r_ID_o, data_r_aux_o, data_r_rdata_o, orphan_err_o,
                         e.id, e.aux, e.rdata);
            end
        end
        do_reset();
        total++;
        if (orphan_err_o !== 1'b0) begin
            bad++;
            $display("FAIL orphan_clear: got %b want 0", orphan_err_o);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive_cycle(1'b1, 1'b1, 1'b0, 9'h001, 8'h01, 32'h0, 1'b0);
        drive_cycle(1'b1, 1'b1, 1'b0, 9'h002, 8'h02, 32'h0, 1'b0);
        drive_cycle(1'b1, 1'b1, 1'b0, 9'h004, 8'h03, 32'h0, 1'b0);
        drive_cycle(1'b1, 1'b1, 1'b1, 9'h008, 8'h04, 32'hFEED_F00D, 1'b1);
        total++;
        if (outstanding_o !== 3'd3 || data_r_valid_o !== 1'b1) begin
            bad++;
            $display("FAIL mid_pre: got cnt=%0d v=%b want 3 1", outstanding_o, data_r_valid_o);
        end
        idle_cycle();
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({data_r_valid_o, data_r_rdata_o, data_r_ID_o, data_r_opc_o, data_r_aux_o} !== '0 ||
            outstanding_o !== 3'd0 || orphan_err_o !== 1'b0) begin
            bad++;
            $display("FAIL mid_async: got v=%b rd=%h id=%h opc=%b aux=%h cnt=%0d orphan=%b want all 0",
                     data_r_valid_o, data_r_rdata_o, data_r_ID_o, data_r_opc_o, data_r_aux_o,
                     outstanding_o, orphan_err_o);
        end
        rst_n = 1'b1;
        model_clear();
        per_gnt_i = 1'b1;
        #1;
        total++;
        if (data_gnt_o !== 1'b1) begin
            bad++;
            $display("FAIL mid_gnt1: got %b want 1", data_gnt_o);
        end
        per_gnt_i = 1'b0;
        #1;
        total++;
        if (data_gnt_o !== 1'b0) begin
            bad++;
            $display("FAIL mid_gnt0: got %b want 0", data_gnt_o);
        end
        @(posedge clk);
        #1;
        // A late response to a pre-reset request has nothing to match.
        drive_cycle(1'b0, 1'b0, 1'b1, 9'h0, 8'h0, 32'h1111_2222, 1'b0);
        total++;
        if (data_r_valid_o !== 1'b0 || orphan_err_o !== morphan || outstanding_o !== 3'd0) begin
            bad++;
            $display("FAIL mid_orphan: got v=%b orphan=%b cnt=%0d want 0 %b 0", data_r_valid_o,
                     orphan_err_o, outstanding_o, morphan);
        end
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_fill_full();
        test_push_pop();
        test_wrap();
        test_orphan();
        test_reset_mid();
        idle_cycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/xbar_slave_id_tracker.md
Name: xbar_slave_id_tracker

Overview:
- Sits downstream of one slave port of the crossbar bridge, between that port and an in-order peripheral or memory target that carries no ID.
- On each granted request, stores the request's ID and AUX in an outstanding-transaction FIFO. Forwards the request with no ID attached.
- On each peripheral response, pops the FIFO head and returns the response to the bridge tagged with data_r_ID_o/data_r_aux_o, registered by one cycle.
- Limits the number of outstanding transactions and flags any response that arrives with no matching request.

Parameters:
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width.
- BE_WIDTH, DATA_WIDTH/8, byte-enable width.
- ID_WIDTH, 9, one-hot master ID width (N_CH0+N_CH1 of the bridge).
- AUX_WIDTH, 8, AUX sideband width.
- MAX_OUTSTANDING, 4, FIFO depth. Must be a power of two and ≥2.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- data_req_i  in  1  request from bridge
- data_add_i  in  ADDR_WIDTH  address
- data_wen_i  in  1  0=store, 1=load
- data_wdata_i  in  DATA_WIDTH  write data
- data_be_i  in  BE_WIDTH  byte enable
- data_ID_i  in  ID_WIDTH  requester ID
- data_aux_i  in  AUX_WIDTH  request AUX
- data_gnt_o  out  1  grant to bridge
- data_r_valid_o  out  1  response valid to bridge
- data_r_rdata_o  out  DATA_WIDTH  response data
- data_r_ID_o  out  ID_WIDTH  response ID
- data_r_opc_o  out  1  response error
- data_r_aux_o  out  AUX_WIDTH  response AUX
- per_req_o  out  1  request to peripheral
- per_add_o  out  ADDR_WIDTH  address
- per_wen_o  out  1  type
- per_wdata_o  out  DATA_WIDTH  write data
- per_be_o  out  BE_WIDTH  byte enable
- per_gnt_i  in  1  peripheral grant
- per_r_valid_i  in  1  peripheral response valid (in order, one per granted request, loads and stores)
- per_r_rdata_i  in  DATA_WIDTH  peripheral read data
- per_r_opc_i  in  1  peripheral error
- outstanding_o  out  $clog2(MAX_OUTSTANDING)+1  current FIFO occupancy
- orphan_err_o  out  1  sticky: response received while FIFO empty

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values:
  - FIFO pointers and count are 0.
  - data_r_valid_o=0, data_r_rdata_o=0, data_r_ID_o=0, data_r_opc_o=0, data_r_aux_o=0.
  - orphan_err_o=0, outstanding_o=0.
- Request path (combinational, zero latency):
  - full = (count==MAX_OUTSTANDING).
  - per_req_o = data_req_i & ~full.
  - data_gnt_o = per_gnt_i & ~full.
  - per_add/wen/wdata/be pass straight through.
- Push when data_req_i & per_gnt_i & ~full: write {data_ID_i, data_aux_i} at the write pointer.
- Pop when per_r_valid_i & (count!=0).
- Full does not consider a same-cycle pop. A request is refused when count==MAX even if a pop occurs in that cycle.
- Simultaneous push and pop (count not full, not empty): count unchanged, both pointers advance.
- Pointers wrap modulo MAX_OUTSTANDING. count spans 0..MAX.
- Response path is registered, 1-cycle latency. At the next clk edge:
  - data_r_valid_o <= pop.
  - When pop, also: data_r_rdata_o <= per_r_rdata_i, data_r_opc_o <= per_r_opc_i, data_r_ID_o/data_r_aux_o <= FIFO head.
  - When no pop, data fields hold their last values.
- A response in the same cycle as a push to an empty FIFO is an orphan. The head is not yet valid, so no pop occurs.
- Orphan condition: per_r_valid_i & (count==0). The response is dropped (no data_r_valid_o), orphan_err_o is set to 1 and stays set until reset.
- FIFO state may only change on push/pop; pointers do not move otherwise.
- Reset mid-operation: all outstanding entries are discarded. Subsequent peripheral responses to pre-reset requests are orphans.
- outstanding_o = count (registered).

Decomposition:
- Shared package: a packed struct for the FIFO entry {ID, AUX} and a function computing the pointer width from MAX_OUTSTANDING.
- One sub-module is natural: xbar_id_fifo, a generic register-file FIFO (push/pop/full/empty/count, async active-low reset, head read combinationally).

Test Plan:
- Single load: data_req_i=1, ID=9'h004, aux=8'h5A, per_gnt_i=1; then per_r_valid_i=1 with rdata=32'hDEADBEEF two cycles later -> one cycle later data_r_valid_o=1, rdata=DEADBEEF, ID=004, aux=5A, opc=0; outstanding_o returns to 0.
- Fill to full (MAX=4): four back-to-back granted requests with IDs 001, 002, 004, 008 and no responses -> fifth cycle data_gnt_o=0, per_req_o=0. Four responses then return IDs 001, 002, 004, 008 in order.
- Simultaneous push/pop at count=2: new request granted and response in the same cycle -> count stays 2; response carries the oldest ID.
- Wrap-around: run 10 request/response pairs with IDs cycling 001..100 -> every response ID matches its request; pointers wrap with no corruption.
- Orphan: per_r_valid_i=1 with the FIFO empty -> no data_r_valid_o; orphan_err_o=1 and stays 1 through later normal traffic until rst_n=0.
- Reset mid-operation: assert rst_n=0 with count=3 -> all outputs are 0 immediately (asynchronously); after release, data_gnt_o follows per_gnt_i and outstanding_o=0.
